// File: rtl/lcd_dice_formatter.sv
// lcd_dice_formatter: latches two die values and streams a fixed 16x2 text frame
// ("D1:x  D2:y" / "SUM:zz") as HD44780 command/data bytes to an LCD controller.
// Ports: CLOCK_50/RESET_N clock and async active-low reset; die1/die2 die values;
//   update refresh request; cmd_valid/cmd_ready/cmd_rs/cmd_data byte handshake;
//   busy while a frame streams; done one-cycle pulse after the last byte.
module lcd_dice_formatter (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [2:0] die1,
  input  logic [2:0] die2,
  input  logic       update,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_rs,
  output logic [7:0] cmd_data,
  output logic       busy,
  output logic       done
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [5:0] LAST_IDX = 6'd33;

  state_t     state, state_next;
  logic [5:0] idx;
  logic       pending;
  logic [2:0] d1_q, d2_q;
  logic       rs_q;
  logic [7:0] data_q;
  logic       done_q;
  logic       start, xfer, last;
  logic [8:0] next_item;

  // 0 and 7 are not die faces; show them as '-'.
  function automatic logic [7:0] die_char(input logic [2:0] d);
    if (d == 3'd0 || d == 3'd7) return 8'h2D;
    return 8'h30 + {5'd0, d};
  endfunction

  // Returns {rs, byte} for frame position i using the latched dice.
  function automatic logic [8:0] frame_item(input logic [5:0] i,
                                            input logic [2:0] a,
                                            input logic [2:0] b);
    logic [3:0] sum;
    logic       ok;
    logic [7:0] tc, oc;
    sum = {1'b0, a} + {1'b0, b};
    ok  = (a != 3'd0) && (a != 3'd7) && (b != 3'd0) && (b != 3'd7);
    if (!ok) begin
      tc = 8'h2D;
      oc = 8'h2D;
    end else if (sum >= 4'd10) begin
      tc = 8'h31;
      oc = 8'h30 + {4'd0, sum - 4'd10};
    end else begin
      tc = 8'h20;
      oc = 8'h30 + {4'd0, sum};
    end
    case (i)
      6'd0:    return {1'b0, 8'h80};
      6'd1:    return {1'b1, 8'h44};  // 'D'
      6'd2:    return {1'b1, 8'h31};  // '1'
      6'd3:    return {1'b1, 8'h3A};  // ':'
      6'd4:    return {1'b1, die_char(a)};
      6'd7:    return {1'b1, 8'h44};  // 'D'
      6'd8:    return {1'b1, 8'h32};  // '2'
      6'd9:    return {1'b1, 8'h3A};  // ':'
      6'd10:   return {1'b1, die_char(b)};
      6'd17:   return {1'b0, 8'hC0};
      6'd18:   return {1'b1, 8'h53};  // 'S'
      6'd19:   return {1'b1, 8'h55};  // 'U'
      6'd20:   return {1'b1, 8'h4D};  // 'M'
      6'd21:   return {1'b1, 8'h3A};  // ':'
      6'd22:   return {1'b1, tc};
      6'd23:   return {1'b1, oc};
      default: return {1'b1, 8'h20};  // padding spaces
    endcase
  endfunction

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    xfer       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          start      = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        xfer = cmd_ready;
        if (cmd_ready && idx == LAST_IDX) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign next_item = frame_item(idx + 6'd1, d1_q, d2_q);

  // The offered byte is registered so it stays put through stalls and holds its
  // last value while idle.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      idx     <= 6'd0;
      pending <= 1'b1;
      d1_q    <= 3'd0;
      d2_q    <= 3'd0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      // An update in the same cycle as a frame start re-arms the follow-up frame.
      pending <= update | (pending & ~start);
      done_q  <= last;
      if (start) begin
        d1_q   <= die1;
        d2_q   <= die2;
        idx    <= 6'd0;
        rs_q   <= 1'b0;
        data_q <= 8'h80;
      end else if (last) begin
        idx <= 6'd0;
      end else if (xfer) begin
        idx    <= idx + 6'd1;
        rs_q   <= next_item[8];
        data_q <= next_item[7:0];
      end
    end
  end

  assign cmd_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign cmd_rs    = rs_q;
  assign cmd_data  = data_q;
  assign done      = done_q;

endmodule

// File: tb/tb_lcd_dice_formatter.sv
module tb_lcd_dice_formatter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] die1, die2;
  logic       update;
  logic       cmd_valid, cmd_ready, cmd_rs;
  logic [7:0] cmd_data;
  logic       busy, done;

  logic [8:0] sb[$];
  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  lcd_dice_formatter dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .die1     (die1),
    .die2     (die2),
    .update   (update),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_rs   (cmd_rs),
    .cmd_data (cmd_data),
    .busy     (busy),
    .done     (done)
  );

  function automatic string dch(input int d);
    if (d >= 1 && d <= 6) return $sformatf("%0d", d);
    return "-";
  endfunction

  task automatic push_frame(input int a, input int b);
    string l1, l2, s;
    bit ok;
    ok = (a >= 1 && a <= 6) && (b >= 1 && b <= 6);
    s  = ok ? $sformatf("%2d", a + b) : "--";
    l1 = {"D1:", dch(a), "  D2:", dch(b), "      "};
    l2 = {"SUM:", s, "          "};
    sb.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) sb.push_back({1'b1, l1[i]});
    sb.push_back({1'b0, 8'hC0});
    for (int i = 0; i < 16; i++) sb.push_back({1'b1, l2[i]});
  endtask

  // mode 0: ready=1; mode 1: random ready; mode 2: ready=1 plus update burst at idx 10.
  task automatic recv(input int mode, input int nframes, input int stop_after,
                      output int ndone, output int nbusy);
    int xfers = 0, k = -1;
    bit gap_check = 0, stalled = 0, finished = 0;
    logic [8:0] held = '0, exp;
    ndone = 0;
    nbusy = 0;
    for (int c = 0; c < 3000 && !finished; c++) begin
      @(negedge clk);
      cmd_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 2) begin
        if (xfers == 10 && k < 0) begin
          die1 = 3'd1;
          die2 = 3'd6;
          k = 0;
        end
        update = (k == 0 || k == 2 || k == 4);
        if (k >= 0) k++;
      end
      if (done === 1'b1) ndone++;
      if (busy === 1'b1) nbusy++;
      if (gap_check) begin
        checks++;
        if (cmd_valid !== 1'b1 || {cmd_rs, cmd_data} !== {1'b0, 8'h80})
          $display("FAIL gap: valid=%b item=%h required valid=1 item=080", cmd_valid, {cmd_rs, cmd_data});
        gap_check = 0;
      end
      if (done === 1'b1 && ndone < nframes) gap_check = 1;
      if (stalled) begin
        checks++;
        if (cmd_valid !== 1'b1 || {cmd_rs, cmd_data} !== held)
          $display("FAIL stall_hold: valid=%b item=%h required valid=1 item=%h", cmd_valid, {cmd_rs, cmd_data}, held);
      end
      stalled = 0;
      if (cmd_valid === 1'b1) begin
        if (cmd_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_byte: got %h required none", {cmd_rs, cmd_data});
          end else begin
            exp = sb.pop_front();
            if ({cmd_rs, cmd_data} !== exp) begin
              errors++;
              $display("FAIL byte[%0d]: got %h required %h", xfers, {cmd_rs, cmd_data}, exp);
            end
          end
          xfers++;
        end else begin
          stalled = 1;
          held = {cmd_rs, cmd_data};
        end
      end
      if (stop_after > 0 && xfers == stop_after) finished = 1;
      if (stop_after == 0 && ndone == nframes) finished = 1;
    end
    if (!finished) begin
      errors++;
      checks++;
      $display("FAIL timeout: xfers=%0d done=%0d required done=%0d", xfers, ndone, nframes);
    end
  endtask

  task automatic test_reset;
    #5;
    checks++;
    if ({cmd_valid, busy, done, cmd_rs, cmd_data} !== 12'h000) begin
      errors++;
      $display("FAIL reset_values: got valid=%b busy=%b done=%b rs=%b data=%h required all 0",
               cmd_valid, busy, done, cmd_rs, cmd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int nd, nb;
    push_frame(3, 4);
    recv(0, 1, 0, nd, nb);
    checks++;
    if (nd != 1 || nb != 34 || sb.size() != 0) begin
      errors++;
      $display("FAIL basic_frame: done=%0d busy=%0d left=%0d required 1 34 0", nd, nb, sb.size());
    end
  endtask

  task automatic test_backpressure;
    int nd, nb;
    die1 = 3'd3; die2 = 3'd4;
    @(negedge clk); update = 1'b1;
    @(negedge clk); update = 1'b0;
    push_frame(3, 4);
    recv(1, 1, 0, nd, nb);
    checks++;
    if (nd != 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL backpressure: done=%0d left=%0d required 1 0", nd, sb.size());
    end
  endtask

  task automatic test_sum_ge10;
    int nd, nb;
    cmd_ready = 1'b0;
    die1 = 3'd6; die2 = 3'd6;
    @(negedge clk); update = 1'b1;
    @(negedge clk); update = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_n: valid=%b required 0", cmd_valid);
    end
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b1 || {cmd_rs, cmd_data} !== {1'b0, 8'h80}) begin
      errors++;
      $display("FAIL latency_n1: valid=%b item=%h required 1 080", cmd_valid, {cmd_rs, cmd_data});
    end
    push_frame(6, 6);
    recv(0, 1, 0, nd, nb);
    die1 = 3'd5; die2 = 3'd5;
    update = 1'b1;
    @(negedge clk); update = 1'b0;
    push_frame(5, 5);
    recv(0, 1, 0, nd, nb);
    checks++;
    if (nd != 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL sum_ge10: done=%0d left=%0d required 1 0", nd, sb.size());
    end
  endtask

  task automatic test_invalid;
    int nd, nb;
    die1 = 3'd0; die2 = 3'd7;
    @(negedge clk); update = 1'b1;
    @(negedge clk); update = 1'b0;
    push_frame(0, 7);
    recv(0, 1, 0, nd, nb);
    checks++;
    if (nd != 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL invalid: done=%0d left=%0d required 1 0", nd, sb.size());
    end
  endtask

  task automatic test_back_to_back;
    int nd, nb, extra;
    die1 = 3'd2; die2 = 3'd2;
    @(negedge clk); update = 1'b1;
    push_frame(2, 2);
    push_frame(1, 6);
    recv(2, 2, 0, nd, nb);
    update = 1'b0;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cmd_valid !== 1'b0) extra++;
    end
    checks++;
    if (nd != 2 || sb.size() != 0 || extra != 0) begin
      errors++;
      $display("FAIL update_collapse: done=%0d left=%0d extra=%0d required 2 0 0", nd, sb.size(), extra);
    end
  endtask

  task automatic test_reset_mid_frame;
    int nd, nb;
    die1 = 3'd4; die2 = 3'd5;
    @(negedge clk); update = 1'b1;
    @(negedge clk); update = 1'b0;
    push_frame(4, 5);
    recv(0, 1, 20, nd, nb);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_valid, busy, done, cmd_rs, cmd_data} !== 12'h000) begin
      errors++;
      $display("FAIL midreset_values: valid=%b busy=%b done=%b rs=%b data=%h required all 0",
               cmd_valid, busy, done, cmd_rs, cmd_data);
    end
    sb.delete();
    cmd_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b1 || {cmd_rs, cmd_data} !== {1'b0, 8'h80}) begin
      errors++;
      $display("FAIL midreset_restart: valid=%b item=%h required 1 080", cmd_valid, {cmd_rs, cmd_data});
    end
    push_frame(4, 5);
    recv(0, 1, 0, nd, nb);
    checks++;
    if (nd != 1 || nb != 34 || sb.size() != 0) begin
      errors++;
      $display("FAIL midreset_frame: done=%0d busy=%0d left=%0d required 1 34 0", nd, nb, sb.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    update = 1'b0;
    cmd_ready = 1'b1;
    die1 = 3'd3;
    die2 = 3'd4;
    test_reset();
    test_basic();
    test_backpressure();
    test_sum_ge10();
    test_invalid();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
